spike_rate_decoder: RTL and testbench

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

---
 rtl/snn_pkg.sv | 17 +
 rtl/sat_counter.sv | 32 +++
 rtl/spike_rate_decoder.sv | 130 +++++++++++++
 tb/tb_spike_rate_decoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network decode blocks: FSM encoding and
// the sentinel reported as first_spike_time when a window saw no spike.
package snn_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned MAX_W   = 32;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_COUNT = 2'd1;
  localparam logic [STATE_W-1:0] ST_HOLD  = 2'd2;

  // Truncate to the field width at the use site; all-ones at any width.
  localparam logic [MAX_W-1:0] NO_SPIKE_TIME = '1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky overflow flag, set by any increment
// that arrives while the count is already at its maximum.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         overflow
);

  localparam logic [W-1:0] COUNT_MAX = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (inc) begin
      if (count == COUNT_MAX) begin
        overflow <= 1'b1;
      end else begin
        count <= count + W'(1);
      end
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Decodes a spike train over a fixed-length window into a rate (spike count)
// and a latency (index of the first spike), held until the consumer accepts.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         spike_in,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] window_len,
  input  logic         result_ready,
  output logic         busy,
  output logic         result_valid,
  output logic [W-1:0] spike_count,
  output logic [W-1:0] first_spike_time,
  output logic         no_spike,
  output logic         overflow
);

  localparam logic [W-1:0] NO_SPIKE_W = W'(NO_SPIKE_TIME);

  state_t       state;
  state_t       state_next;
  logic [W-1:0] captured_len;
  logic [W-1:0] timer;
  logic         first_seen;
  logic         last_index;
  logic         cnt_clear;
  logic         cnt_inc;
  logic         win_open;
  logic         win_step;
  logic         win_done;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and counter control
  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    last_index = (timer == (captured_len - W'(1)));
    case (state)
      ST_IDLE: begin
        if (start && (window_len != '0)) begin
          state_next = ST_COUNT;
          cnt_clear  = 1'b1;
        end
      end
      ST_COUNT: begin
        // Abort wins over completion: the final spike is not counted either.
        if (abort) begin
          state_next = ST_IDLE;
        end else begin
          cnt_inc = spike_in;
          if (last_index) begin
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (result_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign win_open = (state == ST_IDLE)  && (state_next == ST_COUNT);
  assign win_step = (state == ST_COUNT) && !abort;
  assign win_done = (state == ST_COUNT) && (state_next == ST_HOLD);

  // Window bookkeeping and held result fields
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy             <= 1'b0;
      result_valid     <= 1'b0;
      captured_len     <= '0;
      timer            <= '0;
      first_seen       <= 1'b0;
      first_spike_time <= NO_SPIKE_W;
      no_spike         <= 1'b0;
    end else begin
      busy         <= (state_next == ST_COUNT);
      result_valid <= (state_next == ST_HOLD);
      if (win_open) begin
        captured_len <= window_len;
        timer        <= '0;
        first_seen   <= 1'b0;
      end
      if (win_step) begin
        timer <= timer + W'(1);
        if (spike_in && !first_seen) begin
          first_seen       <= 1'b1;
          first_spike_time <= timer;
        end
      end
      if (win_done) begin
        no_spike <= !(first_seen || spike_in);
        if (!(first_seen || spike_in)) begin
          first_spike_time <= NO_SPIKE_W;
        end
      end
    end
  end

  sat_counter #(
    .W (W)
  ) u_count (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .count    (spike_count),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder (W=16 and W=4) plus the standalone
// saturating counter; inputs change and outputs are sampled on the falling edge.
module tb_spike_rate_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        spike_in, start, abort, result_ready;
  logic [15:0] window_len;
  logic        busy, result_valid, no_spike, overflow;
  logic [15:0] spike_count, first_spike_time;

  logic        spike4, start4, abort4, ready4;
  logic [3:0]  len4;
  logic        busy4, rv4, no_spike4, ovf4;
  logic [3:0]  count4, fst4;

  logic        sc_clear, sc_inc, sc_ovf;
  logic [3:0]  sc_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.W(16)) dut (
    .clk(clk), .reset_n(reset_n), .spike_in(spike_in), .start(start), .abort(abort),
    .window_len(window_len), .result_ready(result_ready), .busy(busy),
    .result_valid(result_valid), .spike_count(spike_count),
    .first_spike_time(first_spike_time), .no_spike(no_spike), .overflow(overflow)
  );

  spike_rate_decoder #(.W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .spike_in(spike4), .start(start4), .abort(abort4),
    .window_len(len4), .result_ready(ready4), .busy(busy4),
    .result_valid(rv4), .spike_count(count4),
    .first_spike_time(fst4), .no_spike(no_spike4), .overflow(ovf4)
  );

  sat_counter #(.W(4)) u_sc (
    .clk(clk), .reset_n(reset_n), .clear(sc_clear), .inc(sc_inc),
    .count(sc_count), .overflow(sc_ovf)
  );

  task automatic start_window(input logic [15:0] len);
    start = 1'b1; window_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b exp 0", busy); end
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_rv got %0b exp 0", result_valid); end
    tests++; if (spike_count !== 16'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", spike_count); end
    tests++; if (first_spike_time !== 16'hFFFF) begin fails++; $display("FAIL reset_fst got %h exp ffff", first_spike_time); end
    tests++; if (no_spike !== 1'b0) begin fails++; $display("FAIL reset_no_spike got %0b exp 0", no_spike); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %0b exp 0", overflow); end
  endtask

  task automatic test_basic;
    start_window(16'd10);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %0b exp 1", busy); end
    for (int k = 0; k < 10; k++) begin
      spike_in = (k == 2 || k == 5 || k == 9);
      @(negedge clk);
      if (k < 9) begin
        tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL basic_early_rv at idx %0d got 1 exp 0", k); end
      end
    end
    spike_in = 1'b0;
    tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL basic_rv got %0b exp 1", result_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_hold got %0b exp 0", busy); end
    tests++; if (spike_count !== 16'd3) begin fails++; $display("FAIL basic_count got %0d exp 3", spike_count); end
    tests++; if (first_spike_time !== 16'd2) begin fails++; $display("FAIL basic_fst got %0d exp 2", first_spike_time); end
    tests++; if (no_spike !== 1'b0) begin fails++; $display("FAIL basic_no_spike got %0b exp 0", no_spike); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL basic_ovf got %0b exp 0", overflow); end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL basic_release got %0b exp 0", result_valid); end
  endtask

  task automatic test_no_spike;
    start_window(16'd4);
    repeat (3) @(negedge clk);
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL nospk_early_rv got %0b exp 0", result_valid); end
    @(negedge clk);
    tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL nospk_rv got %0b exp 1", result_valid); end
    tests++; if (spike_count !== 16'd0) begin fails++; $display("FAIL nospk_count got %0d exp 0", spike_count); end
    tests++; if (first_spike_time !== 16'hFFFF) begin fails++; $display("FAIL nospk_fst got %h exp ffff", first_spike_time); end
    tests++; if (no_spike !== 1'b1) begin fails++; $display("FAIL nospk_flag got %0b exp 1", no_spike); end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_abort;
    start_window(16'd8);
    for (int k = 0; k < 4; k++) begin
      spike_in = 1'b1;
      abort = (k == 3);
      @(negedge clk);
    end
    abort = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %0b exp 0", busy); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL abort_rv cycle %0d got 1 exp 0", k); end
    end
    spike_in = 1'b0;
    // Abort on the final window index beats completion.
    start_window(16'd2);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++; if (busy !== 1'b0 || result_valid !== 1'b0) begin fails++; $display("FAIL abort_last got busy=%0b rv=%0b exp 0/0", busy, result_valid); end
    start_window(16'd0);
    result_ready = 1'b1;
    repeat (3) @(negedge clk);
    result_ready = 1'b0;
    tests++; if (busy !== 1'b0 || result_valid !== 1'b0) begin fails++; $display("FAIL zero_len got busy=%0b rv=%0b exp 0/0", busy, result_valid); end
  endtask

  task automatic test_reset_mid;
    start_window(16'd10);
    spike_in = 1'b1;
    repeat (4) @(negedge clk);
    spike_in = 1'b0;
    reset_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || result_valid !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl got busy=%0b rv=%0b exp 0/0", busy, result_valid); end
    tests++; if (spike_count !== 16'd0 || overflow !== 1'b0) begin fails++; $display("FAIL rstmid_count got %0d/%0b exp 0/0", spike_count, overflow); end
    tests++; if (first_spike_time !== 16'hFFFF || no_spike !== 1'b0) begin fails++; $display("FAIL rstmid_fst got %h/%0b exp ffff/0", first_spike_time, no_spike); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_window(16'd3);
    for (int k = 0; k < 3; k++) begin
      spike_in = (k == 2);
      @(negedge clk);
    end
    spike_in = 1'b0;
    tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL rstmid_rv got %0b exp 1", result_valid); end
    tests++; if (spike_count !== 16'd1 || first_spike_time !== 16'd2) begin fails++; $display("FAIL rstmid_result got cnt=%0d fst=%0d exp 1/2", spike_count, first_spike_time); end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_hold;
    start_window(16'd3);
    for (int k = 0; k < 3; k++) begin
      spike_in = (k == 1);
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      spike_in = k[0];
      start = ~k[0];
      abort = k[0];
      window_len = 16'd7;
      @(negedge clk);
      tests++;
      if (result_valid !== 1'b1 || busy !== 1'b0 || spike_count !== 16'd1 ||
          first_spike_time !== 16'd1 || no_spike !== 1'b0) begin
        fails++;
        $display("FAIL hold_stable cycle %0d got rv=%0b busy=%0b cnt=%0d fst=%0d ns=%0b exp 1/0/1/1/0",
                 k, result_valid, busy, spike_count, first_spike_time, no_spike);
      end
    end
    start = 1'b0; abort = 1'b0; spike_in = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    tests++; if (result_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL hold_release got rv=%0b busy=%0b exp 0/0", result_valid, busy); end
  endtask

  task automatic test_back_to_back;
    start_window(16'd5);
    window_len = 16'd2;
    spike_in = 1'b1;
    repeat (4) @(negedge clk);
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL b2b_len_change got rv=1 exp 0"); end
    @(negedge clk);
    spike_in = 1'b0;
    tests++; if (result_valid !== 1'b1 || spike_count !== 16'd5 || first_spike_time !== 16'd0) begin
      fails++; $display("FAIL b2b_first got rv=%0b cnt=%0d fst=%0d exp 1/5/0", result_valid, spike_count, first_spike_time);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    start_window(16'd1);
    @(negedge clk);
    tests++; if (result_valid !== 1'b1 || no_spike !== 1'b1 || spike_count !== 16'd0) begin
      fails++; $display("FAIL b2b_second got rv=%0b ns=%0b cnt=%0d exp 1/1/0", result_valid, no_spike, spike_count);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_saturation;
    start4 = 1'b1; len4 = 4'd15;
    @(negedge clk);
    start4 = 1'b0;
    spike4 = 1'b1;
    repeat (15) @(negedge clk);
    spike4 = 1'b0;
    tests++; if (rv4 !== 1'b1 || count4 !== 4'd15 || fst4 !== 4'd0 || ovf4 !== 1'b0) begin
      fails++; $display("FAIL sat_w4 got rv=%0b cnt=%0d fst=%0d ovf=%0b exp 1/15/0/0", rv4, count4, fst4, ovf4);
    end
    ready4 = 1'b1;
    @(negedge clk);
    ready4 = 1'b0;
    sc_clear = 1'b1;
    @(negedge clk);
    sc_clear = 1'b0;
    sc_inc = 1'b1;
    repeat (20) @(negedge clk);
    sc_inc = 1'b0;
    tests++; if (sc_count !== 4'd15 || sc_ovf !== 1'b1) begin fails++; $display("FAIL sat_counter got cnt=%0d ovf=%0b exp 15/1", sc_count, sc_ovf); end
    sc_clear = 1'b1;
    @(negedge clk);
    sc_clear = 1'b0;
    tests++; if (sc_count !== 4'd0 || sc_ovf !== 1'b0) begin fails++; $display("FAIL sat_clear got cnt=%0d ovf=%0b exp 0/0", sc_count, sc_ovf); end
  endtask

  initial begin
    reset_n = 1'b0;
    spike_in = 1'b0; start = 1'b0; abort = 1'b0; result_ready = 1'b0; window_len = '0;
    spike4 = 1'b0; start4 = 1'b0; abort4 = 1'b0; ready4 = 1'b0; len4 = '0;
    sc_clear = 1'b0; sc_inc = 1'b0;
    #23;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_no_spike();
    test_abort();
    test_reset_mid();
    test_hold();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
